// File: rtl/ram_rr_arbiter.sv
// ram_rr_arbiter: two-client round-robin arbiter driving registered ports of a sync RAM.
// Define RAM_ARB_LOCK_EN to let a client hold its grant across beats via lockN.
module ram_rr_arbiter #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    input  logic          lock0,
    input  logic          lock1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic          ram_wr_en,
    output logic [AW-1:0] ram_wr_addr,
    output logic [DW-1:0] ram_wr_data,
    output logic [AW-1:0] ram_rd_addr,
    input  logic [DW-1:0] ram_rd_data
);
    logic          prio_q, prio_d, wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic [DW-1:0] wr_data_q, wr_data_d, rdata_q, rdata_d;
    logic          v1_q, v1_d, v2_q, v2_d, t1_q, t1_d, t2_q, t2_d;
    logic          pick0, acc, sel, we, frozen;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
`ifdef RAM_ARB_LOCK_EN
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
    state_t state_q, state_d;
    always_comb begin
        pick0 = req0 & (~req1 | ~prio_q);
        gnt0 = ~rst & ((state_q == OWN0) ? req0 : ((state_q == IDLE) & pick0));
        gnt1 = ~rst & ((state_q == OWN1) ? req1 : ((state_q == IDLE) & req1 & ~pick0));
        frozen = state_q != IDLE;
        state_d = (state_q == OWN0) ? ((~req0 | (gnt0 & ~lock0)) ? IDLE : OWN0)
                : (state_q == OWN1) ? ((~req1 | (gnt1 & ~lock1)) ? IDLE : OWN1)
                : (gnt0 & lock0) ? OWN0 : (gnt1 & lock1) ? OWN1 : IDLE;
    end
    always_ff @(posedge clk) state_q <= rst ? IDLE : state_d;
`else
    logic unused_lock;
    assign unused_lock = lock0 | lock1;
    always_comb begin
        pick0 = req0 & (~req1 | ~prio_q);
        gnt0 = ~rst & pick0;
        gnt1 = ~rst & req1 & ~pick0;
        frozen = 1'b0;
    end
`endif
    always_comb begin
        acc = gnt0 | gnt1;
        sel = gnt1;
        we = sel ? we1 : we0;
        addr = sel ? addr1 : addr0;
        wdata = sel ? wdata1 : wdata0;
        prio_d = (acc & ~frozen) ? ~sel : prio_q;
        wr_en_d = acc & we;
        wr_addr_d = (acc & we) ? addr : wr_addr_q;
        wr_data_d = (acc & we) ? wdata : wr_data_q;
        rd_addr_d = (acc & ~we) ? addr : rd_addr_q;
        v1_d = acc & ~we;
        t1_d = sel;
        v2_d = v1_q;
        t2_d = t1_q;
        rdata_d = v2_q ? ram_rd_data : rdata_q;
    end
    // The read tag pipeline is reset so in-flight reads never produce rvalid after rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_addr_q <= '0;
            rdata_q   <= '0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            t1_q      <= 1'b0;
            t2_q      <= 1'b0;
        end else begin
            prio_q    <= prio_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rd_addr_q <= rd_addr_d;
            rdata_q   <= rdata_d;
            v1_q      <= v1_d;
            v2_q      <= v2_d;
            t1_q      <= t1_d;
            t2_q      <= t2_d;
        end
    end
    assign rvalid0     = v2_q & ~t2_q;
    assign rvalid1     = v2_q & t2_q;
    assign rdata       = rdata_d;
    assign ram_wr_en   = wr_en_q;
    assign ram_wr_addr = wr_addr_q;
    assign ram_wr_data = wr_data_q;
    assign ram_rd_addr = rd_addr_q;
endmodule

// File: tb/tb_ram_rr_arbiter.sv
// tb_ram_rr_arbiter: table-driven bench for ram_rr_arbiter with a write-first 16x8 RAM model.
// Lock expectations follow RAM_ARB_LOCK_EN.
module tb_ram_rr_arbiter;
    logic       clk = 1'b0;
    logic       rst, req0, req1, we0, we1, lock0, lock1;
    logic [3:0] addr0, addr1, ram_wr_addr, ram_rd_addr;
    logic [7:0] wdata0, wdata1, rdata, ram_wr_data, ram_rd_data;
    logic       gnt0, gnt1, rvalid0, rvalid1, ram_wr_en;
    logic [7:0] mem [16];
    int checks = 0;
    int errors = 0;

    typedef struct {
        int rst, r0, r1, w0, w1, a0, a1, d0, d1;
        int g0, g1, rv0, rv1, rd, wen, wa, wd, ra;
    } vec_t;
    vec_t vecs [24];
    int eg0 [5];
    int eg1 [5];

    always #5 clk = ~clk;

    ram_rr_arbiter #(.AW(4), .DW(8)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .lock0(lock0), .lock1(lock1), .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
    );

    // Write-first synchronous RAM with one cycle read latency.
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
        ram_rd_data <= (ram_wr_en && ram_wr_addr == ram_rd_addr) ? ram_wr_data : mem[ram_rd_addr];
    end

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst[0];
        req0 = v.r0[0];
        req1 = v.r1[0];
        we0 = v.w0[0];
        we1 = v.w1[0];
        addr0 = v.a0[3:0];
        addr1 = v.a1[3:0];
        wdata0 = v.d0[7:0];
        wdata1 = v.d1[7:0];
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        ram_rd_data = 8'h00;
        vecs = '{
            '{1,1,1,1,0,'hF,0,'hFF,0,  0,0,0,0,0,0,0,0,0},
            '{0,0,0,0,0,0,0,0,0,       0,0,0,0,0,0,0,0,0},
            '{0,0,0,0,0,0,0,0,0,       0,0,0,0,0,0,0,0,0},
            '{0,1,0,1,0,'hA,0,'h55,0,  1,0,0,0,0,0,0,0,0},
            '{0,1,0,0,0,'hA,0,0,0,     1,0,0,0,0,1,'hA,'h55,0},
            '{0,0,0,0,0,0,0,0,0,       0,0,0,0,0,0,'hA,'h55,'hA},
            '{0,0,0,0,0,0,0,0,0,       0,0,1,0,'h55,0,'hA,'h55,'hA},
            '{1,0,0,0,0,0,0,0,0,       0,0,0,0,'h55,0,'hA,'h55,'hA},
            '{0,1,1,1,0,3,3,'hAA,0,    1,0,0,0,0,0,0,0,0},
            '{0,1,1,1,0,3,3,'hAA,0,    0,1,0,0,0,1,3,'hAA,0},
            '{0,1,1,1,0,3,3,'hAA,0,    1,0,0,0,0,0,3,'hAA,3},
            '{0,1,1,1,0,3,3,'hAA,0,    0,1,0,1,'hAA,1,3,'hAA,3},
            '{0,0,0,0,0,0,0,0,0,       0,0,0,0,'hAA,0,3,'hAA,3},
            '{0,1,0,0,0,'hA,0,0,0,     1,0,0,1,'hAA,0,3,'hAA,3},
            '{0,0,1,0,0,0,3,0,0,       0,1,0,0,'hAA,0,3,'hAA,'hA},
            '{0,0,0,0,0,0,0,0,0,       0,0,1,0,'h55,0,3,'hAA,3},
            '{0,0,0,0,0,0,0,0,0,       0,0,0,1,'hAA,0,3,'hAA,3},
            '{0,0,0,0,0,0,0,0,0,       0,0,0,0,'hAA,0,3,'hAA,3},
            '{0,1,0,0,0,'hA,0,0,0,     1,0,0,0,'hAA,0,3,'hAA,3},
            '{1,0,0,0,0,0,0,0,0,       0,0,0,0,'hAA,0,3,'hAA,'hA},
            '{0,0,0,0,0,0,0,0,0,       0,0,0,0,0,0,0,0,0},
            '{0,0,0,0,0,0,0,0,0,       0,0,0,0,0,0,0,0,0},
            '{0,1,1,0,0,1,2,0,0,       1,0,0,0,0,0,0,0,0},
            '{0,0,0,0,0,0,0,0,0,       0,0,0,0,0,0,0,0,1}
        };
`ifdef RAM_ARB_LOCK_EN
        eg0 = '{0,0,0,0,1};
        eg1 = '{1,1,1,1,0};
`else
        eg0 = '{0,1,0,1,0};
        eg1 = '{1,0,1,0,1};
`endif
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; lock0 = 1'b0; lock1 = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk($sformatf("r%0d gnt0", i), int'(gnt0), vecs[i].g0);
            chk($sformatf("r%0d gnt1", i), int'(gnt1), vecs[i].g1);
            chk($sformatf("r%0d rvalid0", i), int'(rvalid0), vecs[i].rv0);
            chk($sformatf("r%0d rvalid1", i), int'(rvalid1), vecs[i].rv1);
            chk($sformatf("r%0d rdata", i), int'(rdata), vecs[i].rd);
            chk($sformatf("r%0d ram_wr_en", i), int'(ram_wr_en), vecs[i].wen);
            chk($sformatf("r%0d ram_wr_addr", i), int'(ram_wr_addr), vecs[i].wa);
            chk($sformatf("r%0d ram_wr_data", i), int'(ram_wr_data), vecs[i].wd);
            chk($sformatf("r%0d ram_rd_addr", i), int'(ram_rd_addr), vecs[i].ra);
        end
        @(negedge clk);
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rst = 1'b0;
            req0 = (i != 0);
            req1 = 1'b1;
            lock1 = (i < 3);
            addr0 = 4'h1;
            addr1 = 4'h2;
            #1;
            chk($sformatf("lock%0d gnt0", i), int'(gnt0), eg0[i]);
            chk($sformatf("lock%0d gnt1", i), int'(gnt1), eg1[i]);
        end
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0; lock1 = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
